stopwatch_100hz: RTL

STOPWATCH_100HZ -- requirements
Module: stopwatch_100hz

---
 rtl/stopwatch_pkg.sv | 38 +++
 rtl/sync_edge_detect.sv | 55 +++++
 rtl/stopwatch_100hz.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the 100 Hz stopwatch.
//   - state_t      : control state (IDLE / RUN / PAUSE)
//   - BCD_MAX      : largest value of a decimal digit
//   - TENS_SEC_MAX : largest value of the tens-of-seconds digit
//   - *_LSB        : bit position of each BCD digit inside the 16-bit display word
//   - digit_limit(): per-digit roll-over value, indexed from hundredths (0)
//                    up to tens of seconds (3)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] TENS_SEC_MAX = 4'd5;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;

    localparam int HUND_LSB   = 0;
    localparam int TENTHS_LSB = 4;
    localparam int ONES_LSB   = 8;
    localparam int TENS_LSB   = 12;

    // Display value one hundredth below a full minute (59.99).
    localparam logic [15:0] DIGITS_MAX = {TENS_SEC_MAX, BCD_MAX, BCD_MAX, BCD_MAX};

    // Value at which a digit rolls back to zero and carries.
    function automatic logic [3:0] digit_limit(input int idx);
        return (idx == NUM_DIGITS - 1) ? TENS_SEC_MAX : BCD_MAX;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous level into the CLK100MHZ domain through a
//   SYNC_STAGES-deep flop chain, then emits a registered one-cycle pulse for
//   every rising edge of the synchronized level. The pulse appears
//   SYNC_STAGES+1 clock cycles after the source edge.
//
//   Parameters
//     SYNC_STAGES : synchronizer depth, legal range 2..4
//   Ports
//     CLK100MHZ  in  system clock (rising edge)
//     reset      in  asynchronous active-high reset, clears every flop
//     async_in   in  asynchronous level to be sampled
//     rise_pulse out single-cycle pulse per rising edge of async_in
// -----------------------------------------------------------------------------
module sync_edge_detect
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;
    logic                   pulse_q;
    logic                   pulse_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
        hist_d  = sync_q[SYNC_STAGES-1];
        // Registering the pulse keeps it glitch-free and adds the +1 cycle.
        pulse_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            pulse_q <= pulse_d;
        end
    end

    assign rise_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_100hz.sv
// -----------------------------------------------------------------------------
// stopwatch_100hz
//   Minute stopwatch with 10 ms resolution. The 100 Hz reference and both
//   buttons are asynchronous levels; each is synchronized and edge-detected
//   into a one-cycle event (tick / start_ev / clear_ev). A three-state
//   controller (IDLE / RUN / PAUSE) counts ticks in BCD while running.
//
//   Parameters
//     SYNC_STAGES    : synchronizer depth on every asynchronous input (2..4)
//     WRAP_AT_MINUTE : 1 = wrap 59.99 -> 00.00 with a rollover pulse,
//                      0 = stop at 59.99 and drop into PAUSE
//   Ports
//     CLK100MHZ      in  100 MHz system clock
//     reset          in  asynchronous active-high reset
//     clk_100hz      in  100 Hz square wave (asynchronous)
//     btn_start_stop in  rising edge toggles run/pause
//     btn_clear      in  rising edge returns to zero/idle
//     digits         out {tens_sec, ones_sec, tenths, hundredths} in BCD
//     running        out high while in RUN
//     rollover       out one-cycle pulse on 59.99 -> 00.00
// -----------------------------------------------------------------------------
module stopwatch_100hz
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int WRAP_AT_MINUTE = 1
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        clk_100hz,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        rollover
);

    logic        tick;
    logic        start_ev;
    logic        clear_ev;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] digits_q;
    logic [15:0] digits_d;
    logic        running_q;
    logic        running_d;
    logic        rollover_q;
    logic        rollover_d;

    // {carry_out, incremented digits}
    logic [16:0] inc_res;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .async_in   (clk_100hz),
        .rise_pulse (tick)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .async_in   (btn_start_stop),
        .rise_pulse (start_ev)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .async_in   (btn_clear),
        .rise_pulse (clear_ev)
    );

    // Ripple BCD increment across the four digits. A digit at (or, defensively,
    // above) its limit returns to zero and passes the carry on; the carry out
    // of the tens-of-seconds digit marks a full minute.
    function automatic logic [16:0] bcd_inc(input logic [15:0] d, input logic cin);
        logic [15:0] r;
        logic        c;
        logic [3:0]  dig;
        r = d;
        c = cin;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = d[i*DIGIT_W +: DIGIT_W];
            if (c) begin
                if (dig >= digit_limit(i)) begin
                    r[i*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    r[i*DIGIT_W +: DIGIT_W] = dig + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    assign inc_res = bcd_inc(digits_q, 1'b1);

    // State register (also holds the registered outputs)
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            digits_q   <= 16'h0000;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        rollover_d = 1'b0;

        if (clear_ev) begin
            // Clear outranks any start or tick arriving in the same cycle.
            state_d  = IDLE;
            digits_d = 16'h0000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (inc_res[16]) begin
                            if (WRAP_AT_MINUTE != 0) begin
                                digits_d   = 16'h0000;
                                rollover_d = 1'b1;
                            end else begin
                                digits_d = DIGITS_MAX;
                                state_d  = PAUSE;
                            end
                        end else begin
                            digits_d = inc_res[15:0];
                        end
                    end
                    // A simultaneous tick is still counted before pausing.
                    if (start_ev) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    // Ticks are ignored here, even when resuming this cycle.
                    if (start_ev) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    digits_d = 16'h0000;
                end
            endcase
        end
    end

    // Output logic: running is registered from the next state so it changes
    // on the same edge as the state itself.
    always_comb begin
        running_d = (state_d == RUN);
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule
